// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB requester arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_NUM_REQ    = 2;
  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_TIMEOUT    = 16;

  // Grant index width; never narrower than one bit so single-bit slices stay legal.
  function automatic int unsigned gnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_GNT_WIDTH = gnt_width(DEF_NUM_REQ);

endpackage

// File: rtl/dff.sv
// Enable flop cell with asynchronous active-low reset to a parameterised value.
module dff #(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Storage: load d when enabled, reset value on rst_ni low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= RST_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first valid requester after last_i, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned GW      = 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [GW-1:0]      last_i,
  output logic               found_c_o,
  output logic [GW-1:0]      idx_c_o
);

  logic [31:0] cand;

  // Scan offsets 1..NUM_REQ so last_i itself is the lowest priority.
  always_comb begin
    found_c_o = 1'b0;
    idx_c_o   = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = 32'(last_i) + 32'(off);
      if (cand >= 32'(NUM_REQ)) begin
        cand = cand - 32'(NUM_REQ);
      end
      if (!found_c_o && valid_i[cand[GW-1:0]]) begin
        found_c_o = 1'b1;
        idx_c_o   = cand[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB completer port among NUM_REQ requesters.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                           pclk,
  input  logic                           presetn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic                           psel,
  output logic                           penable,
  output logic                           pwrite,
  output logic [ADDR_WIDTH-1:0]          paddr,
  output logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH-1:0]          prdata,
  input  logic                           pready,
  input  logic                           pslverr
);

  localparam int unsigned GW      = gnt_width(NUM_REQ);
  localparam int unsigned CW      = $clog2(TIMEOUT);
  localparam int unsigned CMD_W   = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [GW-1:0] LAST_RST = GW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_e              state_q, state_d;
  logic [1:0]              state_raw_q;
  logic [GW-1:0]           grant_q;
  logic [GW-1:0]           last_grant_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    cmd_en;
  logic                    lg_en;
  logic [CMD_W-1:0]        cmd_d, cmd_q;

  logic                    pick_found;
  logic [GW-1:0]           pick_idx;

  logic [NUM_REQ-1:0]      req_ready_d, req_ready_q;
  logic [NUM_REQ-1:0]      rsp_valid_d, rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_d, rsp_rdata_q;
  logic                    rsp_err_d, rsp_err_q;
  logic                    rsp_fire;
  logic                    psel_q, penable_q;

  // Round-robin winner among pending requesters.
  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_pick (
    .valid_i   (req_valid),
    .last_i    (last_grant_q),
    .found_c_o (pick_found),
    .idx_c_o   (pick_idx)
  );

  // Winner's command, captured on the IDLE->SETUP decision.
  assign cmd_d = {req_write[pick_idx],
                  req_addr[32'(pick_idx) * ADDR_WIDTH +: ADDR_WIDTH],
                  req_wdata[32'(pick_idx) * DATA_WIDTH +: DATA_WIDTH]};

  dff #(.WIDTH(2)) u_state (
    .clk_i (pclk), .rst_ni (presetn), .en_i (1'b1),
    .d_i   (state_d), .q_o (state_raw_q)
  );
  assign state_q = arb_state_e'(state_raw_q);

  dff #(.WIDTH(GW)) u_grant (
    .clk_i (pclk), .rst_ni (presetn), .en_i (cmd_en),
    .d_i   (pick_idx), .q_o (grant_q)
  );

  dff #(.WIDTH(GW), .RST_VAL(LAST_RST)) u_last_grant (
    .clk_i (pclk), .rst_ni (presetn), .en_i (lg_en),
    .d_i   (grant_q), .q_o (last_grant_q)
  );

  dff #(.WIDTH(CMD_W)) u_cmd (
    .clk_i (pclk), .rst_ni (presetn), .en_i (cmd_en),
    .d_i   (cmd_d), .q_o (cmd_q)
  );

  dff #(.WIDTH(CW)) u_cnt (
    .clk_i (pclk), .rst_ni (presetn), .en_i (1'b1),
    .d_i   (cnt_d), .q_o (cnt_q)
  );

  // APB address/data come straight from the command register, so they hold while idle.
  assign {pwrite, paddr, pwdata} = cmd_q;

  // Next-state and response decode.
  always_comb begin
    state_d     = state_q;
    cmd_en      = 1'b0;
    lg_en       = 1'b0;
    cnt_d       = cnt_q;
    rsp_fire    = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    req_ready_d = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_found) begin
          state_d     = SETUP;
          cmd_en      = 1'b1;
          req_ready_d = NUM_REQ'(1) << pick_idx;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        lg_en   = 1'b1;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (pready) begin
          state_d     = IDLE;
          rsp_fire    = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite ? '0 : prdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          rsp_fire    = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rsp_valid_d = rsp_fire ? (NUM_REQ'(1) << grant_q) : '0;

  // Registered handshake, response and APB phase outputs.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
    end else begin
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      psel_q      <= (state_d != IDLE);
      penable_q   <= (state_d == ACCESS);
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign psel      = psel_q;
  assign penable   = penable_q;

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

- Shares the single APB completer port of the watchdog (WDT) register slave among `NUM_REQ` internal requesters, for example a host bridge and a debug/config loader.
- Arbitrates round-robin between the requesters.
- Sequences each granted command through the APB SETUP and ACCESS phases, honours `pready` wait states, and aborts stalled transfers on timeout.
- Returns read data and an error flag to the requester that owns the transfer.

## Interface

Parameters:

- `NUM_REQ`, 2: number of requesters, 2..8.
- `ADDR_WIDTH`, 8: APB address width.
- `DATA_WIDTH`, 32: APB data width.
- `TIMEOUT`, 16: maximum ACCESS cycles without `pready` before an abort, ≥2.

Ports:

- `pclk`  in  1: the block's single clock.
- `presetn`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ: per-requester command pending; held until `req_ready`.
- `req_write`  in  NUM_REQ: 1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH: packed addresses; requester i occupies slice i.
- `req_wdata`  in  NUM_REQ*DATA_WIDTH: packed write data.
- `req_ready`  out  NUM_REQ: one-cycle accept pulse to the granted requester.
- `rsp_valid`  out  NUM_REQ: one-cycle completion pulse to the owning requester.
- `rsp_rdata`  out  DATA_WIDTH: read data, valid with `rsp_valid`; 0 for writes.
- `rsp_err`  out  1: `pslverr` or timeout, valid with `rsp_valid`.
- `psel`, `penable`, `pwrite`  out  1 each: APB requester controls.
- `paddr`  out  ADDR_WIDTH.
- `pwdata`  out  DATA_WIDTH.
- `prdata`  in  DATA_WIDTH.
- `pready`, `pslverr`  in  1 each.

## Operation

FSM states:

- **IDLE**
  - `psel`=0, `penable`=0.
  - If any `req_valid` is set, pick a winner round-robin: search starts at `last_grant+1` mod NUM_REQ.
  - Latch the winner's write/addr/wdata into the command registers, store the grant index, and go to SETUP.
  - If no request is pending, stay in IDLE.
- **SETUP**
  - `psel`=1, `penable`=0.
  - `req_ready[grant]`=1 for this cycle only.
  - Update `last_grant` to the grant index.
  - Always go to ACCESS.
- **ACCESS**
  - `psel`=1, `penable`=1.
  - Wait counter increments each cycle `pready`=0.
  - `pready`=1: capture `prdata` (reads only) and `pslverr`; go to IDLE.
  - Counter reaches TIMEOUT−1 with `pready`=0: abort with `rsp_err`=1 and `rsp_rdata`=0; go to IDLE.
- **Response**
  - `rsp_valid[grant]` pulses in the first IDLE cycle after ACCESS, with `rsp_rdata` and `rsp_err` registered.
  - A new arbitration may be decided in that same cycle.

Ordering and request rules:

- Requesters must hold their `req_*` signals stable from assertion through the `req_ready` cycle.
- A requester must not issue a new command before it has received its `rsp_valid`.
- Round-robin guarantees no requester waits more than NUM_REQ−1 transfers.
- `paddr`, `pwrite` and `pwdata` are driven from the command registers. They are stable from SETUP through the end of ACCESS and hold their last value while idle.
- `req_valid` of the owning requester is ignored while its transfer is in flight.

Reset values:

- State = IDLE; `last_grant` = NUM_REQ−1, so requester 0 wins first.
- All outputs are 0.
- Reset asserted mid-transfer:
  - `psel` and `penable` drop immediately (asynchronously).
  - No `rsp_valid` is issued for the killed transfer.

## Timing

- Request seen in IDLE at edge k:
  - SETUP during cycle k+1, with `req_ready` high in that cycle.
  - ACCESS during cycle k+2.
- With `pready`=1 in the first ACCESS cycle:
  - `rsp_valid` occurs in cycle k+3.
  - Minimum request-to-response latency is 3 cycles.
  - Back-to-back throughput is 1 transfer per 3 cycles.
- Each cycle of `pready`=0 adds 1 cycle of latency.
- Timeout fires after exactly TIMEOUT ACCESS cycles, so the response arrives at cycle k+2+TIMEOUT.
- If all requesters assert `req_valid` on the same edge, requester (`last_grant`+1) mod NUM_REQ wins; the others keep waiting.
- `pready` is ignored outside ACCESS.

## Structure

Package `apb_arb_pkg` holds:

- `typedef enum logic [1:0] {IDLE, SETUP, ACCESS}` for the arbiter state.
- Default parameter constants.
- Grant index width, computed as `$clog2(NUM_REQ)`.

Sub-modules:

- Round-robin selection goes in one sub-module, `rr_pick`: combinational; inputs are the `req_valid` vector and `last_grant`; outputs are a found flag and the winner index.
- State, grant and command registers use the existing `dff` flop cell (async active-low reset).

## Test plan

- Single read by requester 0, addr 0x04, `pready`=1, `prdata`=0xDEADBEEF → `req_ready[0]` at k+1, `psel`/`penable`=1/0 then 1/1, `rsp_valid[0]` at k+3 with `rsp_rdata`=0xDEADBEEF and `rsp_err`=0.
- Both requesters valid from reset, writes to 0x00 and 0x08 → requester 0 served first, then requester 1. Two complete 3-cycle transfers; `pwdata` matches each requester's data.
- Requester 0 re-requests continuously while requester 1 also requests → grants alternate 0, 1, 0, 1. No grant to the same requester twice while the other waits.
- `pready` held low 3 cycles, then high with `pslverr`=1 → response at k+6 with `rsp_err`=1; `paddr` stable throughout.
- `pready` stuck low, TIMEOUT=16 → abort at k+18 with `rsp_err`=1 and `rsp_rdata`=0; FSM returns to IDLE and serves the next request normally.
- `presetn` pulsed low during ACCESS → `psel`/`penable` drop immediately, no `rsp_valid`. After release, requester 0 has priority again.
